fir_mac_controller: RTL and testbench

Sequencer for a time-multiplexed, single-MAC FIR datapath that replaces the fully parallel FIR_filter for long tap counts. It accepts one audio sample per valid/ready handshake and writes it into a circular delay-line RAM. It then walks all taps, driving the delay-line and coefficient-ROM read addresses plus the MAC clear/enable strobes, and flags the finished result to the downstream consumer. The MAC, RAM and ROM sit outside this block; this block owns the sequencing only.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_mac_controller_if.sv | 37 +++
 rtl/fir_addr_gen.sv | 43 ++++
 rtl/fir_mac_controller.sv | 162 ++++++++++++++++
 tb/tb_fir_mac_controller.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed single-MAC FIR sequencer:
// state encoding, default geometry and the circular-buffer address helper.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fir_state_e;

  localparam int unsigned TAPS_DEF   = 32'd16;
  localparam int unsigned ADDR_W_DEF = 32'd4;
  localparam int unsigned DATA_W_DEF = 32'd16;

  // Step one slot back in a ring of 'taps' entries; wraps with a compare so
  // non-power-of-two tap counts stay inside the ring.
  function automatic int unsigned mod_dec(input int unsigned val, input int unsigned taps);
    int unsigned res;
    if (val == 32'd0) begin
      res = taps - 32'd1;
    end else begin
      res = val - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_controller_if.sv
// Sample handshake, delay-line/ROM address bus, MAC strobes and result
// handshake of the FIR sequencer, grouped as one bundle.
interface fir_mac_controller_if
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              flush;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    input  sample_in, sample_valid, flush, out_ready,
    output sample_ready, ram_we, ram_waddr, ram_wdata, ram_raddr, coef_addr,
           mac_clr, mac_en, out_valid, busy
  );

  modport slave (
    output sample_in, sample_valid, flush, out_ready,
    input  sample_ready, ram_we, ram_waddr, ram_wdata, ram_raddr, coef_addr,
           mac_clr, mac_en, out_valid, busy
  );

endinterface

// File: rtl/fir_addr_gen.sv
// Tap counter and circular delay-line read address: walks newest-to-oldest
// sample while the coefficient index walks upward from zero.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] tap,
  output logic [ADDR_W-1:0] raddr,
  output logic              last
);

  logic [ADDR_W-1:0] tap_r;
  logic [ADDR_W-1:0] raddr_r;

  // Load the newest-sample slot on accept, then move one tap per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_r   <= {ADDR_W{1'b0}};
      raddr_r <= {ADDR_W{1'b0}};
    end else if (start) begin
      tap_r   <= {ADDR_W{1'b0}};
      raddr_r <= base;
    end else if (step) begin
      tap_r   <= tap_r + ADDR_W'(1'b1);
      raddr_r <= ADDR_W'(mod_dec(32'(raddr_r), TAPS));
    end else begin
      tap_r   <= tap_r;
      raddr_r <= raddr_r;
    end
  end

  assign tap   = tap_r;
  assign raddr = raddr_r;
  assign last  = (tap_r == ADDR_W'(TAPS - 32'd1));

endmodule

// File: rtl/fir_mac_controller.sv
// Sequencer for a single-MAC FIR: writes each accepted sample into the
// circular delay line, walks every tap, then offers the MAC result downstream.
module fir_mac_controller
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_mac_controller_if.master bus
);

  fir_state_e        state_r;
  fir_state_e        next_state_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic              mac_en_r;
  logic              mac_clr_r;
  logic              out_valid_r;

  logic              clr_last_s;
  logic              ready_s;
  logic              accept_s;
  logic              step_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [ADDR_W-1:0] tap_s;
  logic [ADDR_W-1:0] raddr_s;
  logic              last_s;

  assign clr_last_s = (clr_cnt_r == ADDR_W'(TAPS - 32'd1));

  fir_addr_gen #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .start (accept_s),
    .step  (step_s),
    .base  (wr_ptr_r),
    .tap   (tap_s),
    .raddr (raddr_s),
    .last  (last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the delay-line write port and sample handshake.
  always_comb begin
    next_state_s = state_r;
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    ram_we_s     = 1'b0;
    ram_waddr_s  = wr_ptr_r;
    ram_wdata_s  = {DATA_W{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = clr_cnt_r;
        if (clr_last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        ready_s     = !bus.flush;
        ram_wdata_s = bus.sample_in;
        if (bus.flush) begin
          next_state_s = ST_CLEAR;
        end else if (bus.sample_valid) begin
          accept_s     = 1'b1;
          ram_we_s     = 1'b1;
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          step_s       = 1'b1;
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_CLEAR;
      end
    endcase
  end

  // Clear sweep counter and circular write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt_r <= {ADDR_W{1'b0}};
      wr_ptr_r  <= {ADDR_W{1'b0}};
    end else begin
      if (state_r == ST_CLEAR && !clr_last_s) begin
        clr_cnt_r <= clr_cnt_r + ADDR_W'(1'b1);
      end else begin
        clr_cnt_r <= {ADDR_W{1'b0}};
      end
      if (state_r == ST_CLEAR && clr_last_s) begin
        wr_ptr_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
        wr_ptr_r <= (wr_ptr_r == ADDR_W'(TAPS - 32'd1)) ? {ADDR_W{1'b0}}
                                                         : wr_ptr_r + ADDR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
    end
  end

  // MAC strobes trail the read addresses by the one-cycle RAM/ROM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_en_r    <= 1'b0;
      mac_clr_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      mac_en_r    <= (state_r == ST_RUN);
      mac_clr_r   <= (state_r == ST_RUN) && (tap_s == {ADDR_W{1'b0}});
      out_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // The write strobe is decoded from state, so it is masked while reset is held.
  assign bus.ram_we       = ram_we_s & reset;
  assign bus.ram_waddr    = ram_waddr_s;
  assign bus.ram_wdata    = ram_wdata_s;
  assign bus.sample_ready = ready_s;
  assign bus.ram_raddr    = raddr_s;
  assign bus.coef_addr    = tap_s;
  assign bus.mac_en       = mac_en_r;
  assign bus.mac_clr      = mac_clr_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_controller.sv
// Self-checking bench: a 16-tap and a 5-tap controller, selected one at a time,
// checked cycle by cycle against a transaction-level model of the schedule.
module tb_fir_mac_controller;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        flush;
  logic        out_ready;
  int          checks;
  int          errors;
  int          taps;
  int          exp_wp;

  fir_mac_controller_if #(.ADDR_W(4), .DATA_W(16)) b16 ();
  fir_mac_controller_if #(.ADDR_W(4), .DATA_W(16)) b5 ();

  assign b16.sample_in    = sample_in;
  assign b16.sample_valid = sample_valid & ~sel;
  assign b16.flush        = flush & ~sel;
  assign b16.out_ready    = sel ? 1'b1 : out_ready;
  assign b5.sample_in     = sample_in;
  assign b5.sample_valid  = sample_valid & sel;
  assign b5.flush         = flush & sel;
  assign b5.out_ready     = sel ? out_ready : 1'b1;

  fir_mac_controller #(.TAPS(16), .ADDR_W(4), .DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .bus(b16));
  fir_mac_controller #(.TAPS(5), .ADDR_W(4), .DATA_W(16)) u_dut5 (
    .clk(clk), .reset(reset), .bus(b5));

  logic        v_ready, v_we, v_en, v_clr, v_ov, v_busy;
  logic [3:0]  v_waddr, v_raddr, v_coef;
  logic [15:0] v_wdata;
  assign v_ready = sel ? b5.sample_ready : b16.sample_ready;
  assign v_we    = sel ? b5.ram_we      : b16.ram_we;
  assign v_en    = sel ? b5.mac_en      : b16.mac_en;
  assign v_clr   = sel ? b5.mac_clr     : b16.mac_clr;
  assign v_ov    = sel ? b5.out_valid   : b16.out_valid;
  assign v_busy  = sel ? b5.busy        : b16.busy;
  assign v_waddr = sel ? b5.ram_waddr   : b16.ram_waddr;
  assign v_raddr = sel ? b5.ram_raddr   : b16.ram_raddr;
  assign v_coef  = sel ? b5.coef_addr   : b16.coef_addr;
  assign v_wdata = sel ? b5.ram_wdata   : b16.ram_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expects to be called in the first CLEAR cycle; ends in the first IDLE cycle.
  task automatic clear_seq();
    for (int k = 0; k < taps; k++) begin
      chk("clr_we", v_we, 1);
      chk("clr_waddr", v_waddr, k);
      chk("clr_wdata", v_wdata, 0);
      chk("clr_ready", v_ready, 0);
      @(negedge clk); sample_valid = 1'b0; flush = 1'b0; #1;
    end
    chk("clr_done_ready", v_ready, 1);
    chk("clr_done_busy", v_busy, 0);
    chk("clr_done_we", v_we, 0);
    exp_wp = 0;
  endtask

  // One full transaction: idle gap, accept, tap walk, drain, result handshake.
  task automatic do_sample(input logic [15:0] d, input int gap, input int hold, input bit frun);
    int base;
    int waited;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); sample_valid = 1'b0; #1;
      chk("idle_ready", v_ready, 1);
      chk("idle_we", v_we, 0);
    end
    waited = 0;
    do begin
      @(negedge clk); sample_valid = 1'b1; sample_in = d; #1;
      waited++;
    end while (!v_ready && waited < 64);
    chk("accept_wait", waited, 1);
    base = exp_wp;
    chk("wr_we", v_we, 1);
    chk("wr_addr", v_waddr, base);
    chk("wr_data", v_wdata, d);
    exp_wp = (exp_wp + 1) % taps;
    for (int k = 0; k <= taps; k++) begin
      @(negedge clk); sample_valid = 1'b0; flush = frun && (k == 2); #1;
      if (k < taps) begin
        chk("raddr", v_raddr, (base - k + taps) % taps);
        chk("coef", v_coef, k);
      end
      chk("mac_en", v_en, (k >= 1));
      chk("mac_clr", v_clr, (k == 1));
      chk("run_ov", v_ov, 0);
      chk("run_we", v_we, 0);
      chk("run_ready", v_ready, 0);
    end
    flush = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk); out_ready = (h == hold); #1;
      chk("done_ov", v_ov, 1);
      chk("done_en", v_en, 0);
      chk("done_we", v_we, 0);
      chk("done_ready", v_ready, 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    sel = 1'b0; taps = 16; exp_wp = 0;
    reset = 1'b0; sample_in = 16'h0000; sample_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // Reset state of the 16-tap controller.
    @(negedge clk); #1;
    chk("rst_we", v_we, 0);
    chk("rst_en", v_en, 0);
    chk("rst_clr", v_clr, 0);
    chk("rst_ov", v_ov, 0);
    chk("rst_raddr", v_raddr, 0);
    chk("rst_coef", v_coef, 0);
    chk("rst_ready", v_ready, 0);
    chk("rst_busy", v_busy, 1);
    @(negedge clk); reset = 1'b1; #1;
    clear_seq();

    // Directed sample, held result, then a random one.
    do_sample(16'h1234, 0, 0, 1'b0);
    do_sample(16'hbeef, 0, 10, 1'b0);
    do_sample(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);

    // Reset seven cycles into a tap walk aborts everything.
    @(negedge clk); sample_valid = 1'b1; sample_in = 16'($urandom); #1;
    chk("rst_run_accept", v_ready, 1);
    for (int k = 1; k < 7; k++) begin
      @(negedge clk); sample_valid = 1'b0; #1;
    end
    @(negedge clk); #1;
    chk("pre_rst_en", v_en, 1);
    reset = 1'b0; #1;
    chk("mid_rst_en", v_en, 0);
    chk("mid_rst_ov", v_ov, 0);
    chk("mid_rst_we", v_we, 0);
    chk("mid_rst_busy", v_busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    clear_seq();
    do_sample(16'($urandom), 0, 0, 1'b0);

    // Switch to the 5-tap controller, cleared and idle since reset release.
    sel = 1'b1; taps = 5; exp_wp = 0;
    for (int i = 0; i < 8; i++) begin
      do_sample(16'($urandom), 0, 0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      do_sample(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    // flush wins over a simultaneous sample and restarts the clear sweep.
    @(negedge clk); flush = 1'b1; sample_valid = 1'b1; sample_in = 16'h5a5a; #1;
    chk("flush_ready", v_ready, 0);
    chk("flush_we", v_we, 0);
    @(negedge clk); flush = 1'b0; sample_valid = 1'b0; #1;
    clear_seq();
    do_sample(16'($urandom), 0, 0, 1'b0);
    do_sample(16'($urandom), 1, 1, 1'b1);
    do_sample(16'($urandom), 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
